// File: rtl/lfu_counter_bank_if.sv
// Access / LFU-comparator / eviction bundle for lfu_counter_bank.
// The slave modport is the counter bank; the master modport is the controller plus comparator side.
interface lfu_counter_bank_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
);
  logic             acc_valid;
  logic             acc_ready;
  logic [IDX_W-1:0] acc_index;
  logic             acc_hit;
  logic [1:0]       acc_way;
  logic [WIDTH-1:0] count0;
  logic [WIDTH-1:0] count1;
  logic [WIDTH-1:0] count2;
  logic [WIDTH-1:0] count3;
  logic [1:0]       victim_sel;
  logic             evict_valid;
  logic [1:0]       evict_way;
  logic [IDX_W-1:0] evict_index;

  modport slave (
    input  acc_valid, acc_index, acc_hit, acc_way, victim_sel,
    output acc_ready, count0, count1, count2, count3,
           evict_valid, evict_way, evict_index
  );

  modport master (
    output acc_valid, acc_index, acc_hit, acc_way, victim_sel,
    input  acc_ready, count0, count1, count2, count3,
           evict_valid, evict_way, evict_index
  );
endinterface

// File: rtl/lfu_counter_bank.sv
// Per-set 4-way access-frequency counters for an LFU cache: snapshot, update on hit/fill, write back.
// Optional: define LFU_AGING_EN to halve a set's counts when a saturated way is hit again.
module lfu_counter_bank #(
  parameter int WIDTH    = 4,
  parameter int NUM_SETS = 4,
  parameter int IDX_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  lfu_counter_bank_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, EVAL, WRITE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] cnt      [NUM_SETS][4];
  logic [WIDTH-1:0] snap     [4];
  logic [WIDTH-1:0] snap_nxt [4];
  logic [IDX_W-1:0] idx_q;
  logic             hit_q;
  logic [1:0]       way_q;
  logic             evict_q;
  logic [1:0]       evict_way_q;
  logic [IDX_W-1:0] evict_index_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        accept = bus.acc_valid;
        if (bus.acc_valid) state_nxt = EVAL;
      end
      EVAL:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Update applied to the snapshot during EVAL.
  always_comb begin
    snap_nxt = snap;
    if (hit_q) begin
      if (snap[way_q] != CNT_MAX) begin
        snap_nxt[way_q] = snap[way_q] + 1'b1;
      end else begin
`ifdef LFU_AGING_EN
        for (int w = 0; w < 4; w++) snap_nxt[w] = snap[w] >> 1;
        snap_nxt[way_q] = (snap[way_q] >> 1) + 1'b1;
`else
        snap_nxt[way_q] = CNT_MAX;
`endif
      end
    end else begin
      snap_nxt[bus.victim_sel] = WIDTH'(1);
    end
  end

  // NOTE: the counter array is cleared on reset because the LFU ordering must restart from zero;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < 4; w++) cnt[s][w] <= '0;
      for (int w = 0; w < 4; w++) snap[w] <= '0;
      idx_q         <= '0;
      hit_q         <= 1'b0;
      way_q         <= '0;
      evict_q       <= 1'b0;
      evict_way_q   <= '0;
      evict_index_q <= '0;
    end else begin
      evict_q <= 1'b0;
      if (accept) begin
        idx_q <= bus.acc_index;
        hit_q <= bus.acc_hit;
        way_q <= bus.acc_way;
        snap  <= cnt[bus.acc_index];
      end
      if (state == EVAL) begin
        snap <= snap_nxt;
        if (!hit_q) begin
          evict_q       <= 1'b1;
          evict_way_q   <= bus.victim_sel;
          evict_index_q <= idx_q;
        end
      end
      if (state == WRITE) cnt[idx_q] <= snap;
    end
  end

  assign bus.acc_ready   = (state == IDLE);
  assign bus.count0      = snap[0];
  assign bus.count1      = snap[1];
  assign bus.count2      = snap[2];
  assign bus.count3      = snap[3];
  // A reset landing in WRITE aborts the access, so its eviction pulse is suppressed immediately.
  assign bus.evict_valid = evict_q & ~reset;
  assign bus.evict_way   = evict_way_q;
  assign bus.evict_index = evict_index_q;
endmodule

// File: tb/tb_lfu_counter_bank.sv
// Self-checking bench for lfu_counter_bank: directed scenarios plus randomized accesses
// compared against an array-based frequency-count model.
module tb_lfu_counter_bank;
  localparam int WIDTH = 4;
  localparam int IDX_W = 2;
  localparam int NSETS = 4;
  localparam int CMAX  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   model [NSETS][4];

  always #5 clk = ~clk;

  lfu_counter_bank_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  lfu_counter_bank #(.WIDTH(WIDTH), .NUM_SETS(NSETS), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] count_of(input int w);
    case (w)
      0:       return 32'(bus.count0);
      1:       return 32'(bus.count1);
      2:       return 32'(bus.count2);
      default: return 32'(bus.count3);
    endcase
  endfunction

  task automatic check_counts(input string tag, input int exp [4]);
    for (int w = 0; w < 4; w++) check($sformatf("%s_c%0d", tag, w), count_of(w), 32'(exp[w]));
  endtask

  // Comparator stand-in: least count, lowest way on ties.
  function automatic int least_way(input int c [4]);
    int best = 0;
    for (int w = 1; w < 4; w++) if (c[w] < c[best]) best = w;
    return best;
  endfunction

  // Frequency-count rules: hit bumps a way (saturating or aging), a fill restarts the victim at one.
  function automatic void expected_after(input int pre [4], input bit hit, input int way,
                                         input int victim, output int post [4]);
    post = pre;
    if (!hit) post[victim] = 1;
    else if (pre[way] < CMAX) post[way] = pre[way] + 1;
    else begin
`ifdef LFU_AGING_EN
      for (int w = 0; w < 4; w++) post[w] = pre[w] / 2;
      post[way] = pre[way] / 2 + 1;
`else
      post[way] = CMAX;
`endif
    end
  endfunction

  // One complete access. victim_in: >=0 fixed, -1 comparator model, -2 random.
  // noise keeps a conflicting request asserted while the block is busy.
  task automatic access(input int idx, input bit hit, input int way, input int victim_in,
                        input bit noise);
    int pre [4];
    int post [4];
    int victim;
    pre = model[idx];
    if (victim_in >= 0)       victim = victim_in;
    else if (victim_in == -1) victim = least_way(pre);
    else                      victim = int'($urandom_range(0, 3));
    expected_after(pre, hit, way, victim, post);

    check("ready_at_issue", 32'(bus.acc_ready), 1);
    bus.acc_valid  = 1'b1;
    bus.acc_index  = IDX_W'(idx);
    bus.acc_hit    = hit;
    bus.acc_way    = 2'(way);
    bus.victim_sel = 2'(victim);
    @(posedge clk); #1;
    bus.acc_valid = noise;
    if (noise) begin
      bus.acc_index = IDX_W'(idx + 1);
      bus.acc_hit   = ~hit;
      bus.acc_way   = 2'(way + 1);
    end
    @(negedge clk);
    check("eval_ready", 32'(bus.acc_ready), 0);
    check("eval_evict", 32'(bus.evict_valid), 0);
    check_counts("eval", pre);
    @(posedge clk); #1;
    if (noise) bus.victim_sel = 2'(victim + 1);
    @(negedge clk);
    check("write_ready", 32'(bus.acc_ready), 0);
    check("write_evict", 32'(bus.evict_valid), 32'(!hit));
    if (!hit) begin
      check("evict_way", 32'(bus.evict_way), 32'(victim));
      check("evict_index", 32'(bus.evict_index), 32'(idx));
    end
    check_counts("write", post);
    @(posedge clk); #1;
    bus.acc_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.acc_ready), 1);
    check("idle_evict", 32'(bus.evict_valid), 0);
    check_counts("idle", post);
    model[idx] = post;
  endtask

  initial begin
    int exp [4];
    reset          = 1'b1;
    bus.acc_valid  = 1'b0;
    bus.acc_index  = '0;
    bus.acc_hit    = 1'b0;
    bus.acc_way    = '0;
    bus.victim_sel = '0;
    for (int s = 0; s < NSETS; s++) for (int w = 0; w < 4; w++) model[s][w] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state.
    exp = '{0, 0, 0, 0};
    check_counts("reset", exp);
    check("reset_ready", 32'(bus.acc_ready), 1);
    check("reset_evict", 32'(bus.evict_valid), 0);
    check("reset_evict_way", 32'(bus.evict_way), 0);
    check("reset_evict_index", 32'(bus.evict_index), 0);

    // First hit: set 0 way 2.
    access(0, 1'b1, 2, 0, 1'b0);
    exp = '{0, 0, 1, 0};
    check_counts("first_hit", exp);

    // Set 1 preloaded to 3,1,2,5 then a miss choosing way 1, then a second miss.
    repeat (3) access(1, 1'b1, 0, 0, 1'b0);
    access(1, 1'b1, 1, 0, 1'b0);
    repeat (2) access(1, 1'b1, 2, 0, 1'b0);
    repeat (5) access(1, 1'b1, 3, 0, 1'b0);
    access(1, 1'b0, 0, 1, 1'b0);
    exp = '{3, 1, 2, 5};
    check_counts("set1_after_miss", exp);
    access(1, 1'b0, 0, 2, 1'b0);
    exp = '{3, 1, 1, 5};
    check_counts("set1_second_miss", exp);

    // 16 hits on set 2 way 3.
    repeat (16) access(2, 1'b1, 3, 0, 1'b0);
`ifndef LFU_AGING_EN
    exp = '{0, 0, 0, 15};
    check_counts("saturate", exp);
`else
    // Set 3 brought to 15,6,7,0, then a hit on the saturated way.
    repeat (15) access(3, 1'b1, 0, 0, 1'b0);
    repeat (6)  access(3, 1'b1, 1, 0, 1'b0);
    repeat (7)  access(3, 1'b1, 2, 0, 1'b0);
    access(3, 1'b1, 0, 0, 1'b0);
    exp = '{8, 3, 3, 0};
    check_counts("aging", exp);
`endif

    // Conflicting requests while busy must be ignored.
    access(0, 1'b1, 1, 0, 1'b1);
    access(1, 1'b0, 0, -1, 1'b1);
    for (int s = 0; s < NSETS; s++) access(s, 1'b1, s, 0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++)
      access(int'($urandom_range(0, NSETS - 1)), 1'(($urandom_range(0, 2)) != 0),
             int'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? -1 : -2,
             1'($urandom_range(0, 1)));

    // Reset during the WRITE cycle of a miss.
    bus.acc_valid  = 1'b1;
    bus.acc_index  = IDX_W'(1);
    bus.acc_hit    = 1'b0;
    bus.victim_sel = 2'd2;
    @(posedge clk); #1;
    bus.acc_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_evict", 32'(bus.evict_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    exp = '{0, 0, 0, 0};
    check_counts("abort", exp);
    check("abort_ready", 32'(bus.acc_ready), 1);
    check("abort_evict_after", 32'(bus.evict_valid), 0);
    check("abort_evict_way", 32'(bus.evict_way), 0);
    check("abort_evict_index", 32'(bus.evict_index), 0);
    for (int s = 0; s < NSETS; s++) for (int w = 0; w < 4; w++) model[s][w] = 0;
    access(1, 1'b1, 3, 0, 1'b0);
    access(3, 1'b0, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
